// File: rtl/topk_pkg.sv
// Shared top-k datapath types: sideband control word, sort direction and the
// merge-backend stage-count helper.
package topk_pkg;

   typedef struct packed {
      logic [5:0] id;
      logic       first;
      logic       last;
   } ctrl_t;

   typedef enum logic {
      SORT_DESC = 1'b0,
      SORT_ASC  = 1'b1
   } sort_dir_e;

   function automatic int be_stages(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/bitonic_cas_en.sv
// Registered compare-exchange with enable. lo_o takes the element that belongs at
// the lower index for the requested direction. Tag pair exists under TOPK_BE_IDX_EN.
module bitonic_cas_en
   import topk_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int IDXWIDTH  = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 dir_i,
   input  logic [DATAWIDTH-1:0] a_i,
   input  logic [DATAWIDTH-1:0] b_i,
`ifdef TOPK_BE_IDX_EN
   input  logic [IDXWIDTH-1:0]  a_idx_i,
   input  logic [IDXWIDTH-1:0]  b_idx_i,
   output logic [IDXWIDTH-1:0]  lo_idx_o,
   output logic [IDXWIDTH-1:0]  hi_idx_o,
`endif
   output logic [DATAWIDTH-1:0] lo_o,
   output logic [DATAWIDTH-1:0] hi_o
);

   if (IDXWIDTH < 1) begin : g_bad_idxwidth
      $error("IDXWIDTH must be at least 1");
   end

   logic asc;
   logic swap;

   // Strict comparison only: equal elements never move, keeping tag order stable.
   assign asc  = (sort_dir_e'(dir_i) == SORT_ASC);
   assign swap = asc ? (a_i > b_i) : (b_i > a_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lo_o <= '0;
         hi_o <= '0;
      end else if (en_i) begin
         lo_o <= swap ? b_i : a_i;
         hi_o <= swap ? a_i : b_i;
      end
   end

`ifdef TOPK_BE_IDX_EN
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lo_idx_o <= '0;
         hi_idx_o <= '0;
      end else if (en_i) begin
         lo_idx_o <= swap ? b_idx_i : a_idx_i;
         hi_idx_o <= swap ? a_idx_i : b_idx_i;
      end
   end
`endif

endmodule

// File: rtl/bitonic_merge_be_n.sv
// Pipelined bitonic merge backend: log2(N) compare-exchange columns behind one global
// enable. Index tags travel with their elements when TOPK_BE_IDX_EN is defined.
module bitonic_merge_be_n
   import topk_pkg::*;
#(
   parameter int DATAWIDTH  = 8,
   parameter int DATALENGTH = 8,
   parameter int IDXWIDTH   = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic                                  valid_i,
   output logic                                  ready_o,
   input  logic                                  dir_i,
   input  ctrl_t                                 ctrl_i,
   input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]  x_i,
`ifdef TOPK_BE_IDX_EN
   input  logic [DATALENGTH-1:0][IDXWIDTH-1:0]   x_idx_i,
   output logic [DATALENGTH-1:0][IDXWIDTH-1:0]   y_idx_o,
`endif
   output logic                                  valid_o,
   input  logic                                  ready_i,
   output ctrl_t                                 ctrl_o,
   output logic [DATALENGTH-1:0][DATAWIDTH-1:0]  y_o
);

   localparam int S = be_stages(DATALENGTH);

   if (DATALENGTH < 4 || (DATALENGTH & (DATALENGTH - 1)) != 0) begin : g_bad_length
      $error("DATALENGTH must be a power of two and at least 4");
   end

   logic en;
   logic [DATALENGTH-1:0][DATAWIDTH-1:0] stg [0:S];
`ifdef TOPK_BE_IDX_EN
   logic [DATALENGTH-1:0][IDXWIDTH-1:0]  tg  [0:S];
`endif

   logic  [S:1]   vld_p;
   logic  [S-1:1] dir_p;
   ctrl_t [S:1]   ctrl_p;

   assign en      = ready_i | ~valid_o;
   assign ready_o = en;

   // The last stage's direction would never be consumed, so dir stops one short.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_p  <= '0;
         dir_p  <= '0;
         ctrl_p <= '0;
      end else if (en) begin
         vld_p[1]  <= valid_i;
         dir_p[1]  <= dir_i;
         ctrl_p[1] <= ctrl_i;
         for (int s = 2; s <= S; s++) begin
            vld_p[s]  <= vld_p[s-1];
            ctrl_p[s] <= ctrl_p[s-1];
         end
         for (int s = 2; s <= S - 1; s++) begin
            dir_p[s] <= dir_p[s-1];
         end
      end
   end

   assign stg[0] = x_i;
`ifdef TOPK_BE_IDX_EN
   assign tg[0]  = x_idx_i;
`endif

   for (genvar s = 1; s <= S; s++) begin : g_stage
      localparam int D = (s == 1) ? 1 : (DATALENGTH >> s);
      logic stage_dir;

      if (s == 1) begin : g_dir
         assign stage_dir = dir_i;
      end else begin : g_dir
         assign stage_dir = dir_p[s-1];
      end

      // Stage 1 folds the second half onto the first; later stages use distance D.
      for (genvar p = 0; p < DATALENGTH / 2; p++) begin : g_cas
         localparam int LO = (s == 1) ? p : ((p / D) * 2 * D + (p % D));
         localparam int HI = (s == 1) ? (DATALENGTH - 1 - p) : (LO + D);

         bitonic_cas_en #(
            .DATAWIDTH (DATAWIDTH),
            .IDXWIDTH  (IDXWIDTH)
         ) u_cas (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .en_i     (en),
            .dir_i    (stage_dir),
            .a_i      (stg[s-1][LO]),
            .b_i      (stg[s-1][HI]),
`ifdef TOPK_BE_IDX_EN
            .a_idx_i  (tg[s-1][LO]),
            .b_idx_i  (tg[s-1][HI]),
            .lo_idx_o (tg[s][LO]),
            .hi_idx_o (tg[s][HI]),
`endif
            .lo_o     (stg[s][LO]),
            .hi_o     (stg[s][HI])
         );
      end
   end

   assign valid_o = vld_p[S];
   assign ctrl_o  = ctrl_p[S];
   assign y_o     = stg[S];
`ifdef TOPK_BE_IDX_EN
   assign y_idx_o = tg[S];
`endif

endmodule

// File: tb/tb_bitonic_merge_be_n.sv
// Directed bench for bitonic_merge_be_n at N=8: ordering, latency, backpressure,
// reset and mixed-direction streaming; tag checks appear when TOPK_BE_IDX_EN is set.
module tb_bitonic_merge_be_n;
   import topk_pkg::*;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int IW = 8;
   localparam int S  = 3;

   typedef logic [N-1:0][W-1:0]  vec_t;
   typedef logic [N-1:0][IW-1:0] tvec_t;

   logic  clk = 1'b0;
   logic  rstn_i;
   logic  valid_i;
   logic  ready_o;
   logic  dir_i;
   ctrl_t ctrl_i;
   vec_t  x_i;
   logic  valid_o;
   logic  ready_i;
   ctrl_t ctrl_o;
   vec_t  y_o;
`ifdef TOPK_BE_IDX_EN
   tvec_t x_idx_i;
   tvec_t y_idx_o;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bitonic_merge_be_n #(
      .DATAWIDTH  (W),
      .DATALENGTH (N),
      .IDXWIDTH   (IW)
   ) dut (
      .clk_i   (clk),
      .rstn_i  (rstn_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .dir_i   (dir_i),
      .ctrl_i  (ctrl_i),
      .x_i     (x_i),
`ifdef TOPK_BE_IDX_EN
      .x_idx_i (x_idx_i),
      .y_idx_o (y_idx_o),
`endif
      .valid_o (valid_o),
      .ready_i (ready_i),
      .ctrl_o  (ctrl_o),
      .y_o     (y_o)
   );

   function automatic vec_t v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      vec_t v;
      v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
      v[4] = W'(a4); v[5] = W'(a5); v[6] = W'(a6); v[7] = W'(a7);
      return v;
   endfunction

   function automatic vec_t sort_range(input vec_t v, input int lo, input int hi, input logic asc);
      vec_t         r;
      logic [W-1:0] t;
      r = v;
      for (int i = lo + 1; i <= hi; i++) begin
         for (int j = i; j > lo; j--) begin
            if (asc ? (r[j] < r[j-1]) : (r[j] > r[j-1])) begin
               t = r[j]; r[j] = r[j-1]; r[j-1] = t;
            end
         end
      end
      return r;
   endfunction

   function automatic vec_t half_sorted(input vec_t v, input logic asc);
      return sort_range(sort_range(v, 0, N/2 - 1, asc), N/2, N - 1, asc);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i = 1'b0;
      dir_i   = 1'b0;
      ctrl_i  = '0;
      x_i     = '0;
`ifdef TOPK_BE_IDX_EN
      for (int i = 0; i < N; i++) x_idx_i[i] = IW'(i);
`endif
   endtask

   task automatic test_reset();
      rstn_i  = 1'b0;
      ready_i = 1'b0;
      idle_inputs();
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      n_vec++;
      if (y_o !== '0) begin n_err++; $display("FAIL reset_y: got %h want 0", y_o); end
      n_vec++;
      if (ctrl_o !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", ctrl_o); end
      n_vec++;
      if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
      tick();
      tick();
      rstn_i  = 1'b1;
      ready_i = 1'b1;
      tick();
   endtask

   task automatic test_desc();
      vec_t exp_y;
      exp_y   = v8(8, 7, 6, 5, 4, 3, 2, 1);
      valid_i = 1'b1;
      dir_i   = 1'b0;
      ctrl_i  = ctrl_t'(8'h5A);
      x_i     = v8(7, 5, 3, 1, 8, 6, 4, 2);
      tick();
      idle_inputs();
      tick();
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL desc_early: valid_o got %b want 0", valid_o); end
      tick();
      n_vec++;
      if (valid_o !== 1'b1) begin n_err++; $display("FAIL desc_valid: got %b want 1", valid_o); end
      n_vec++;
      if (y_o !== exp_y) begin n_err++; $display("FAIL desc_y: got %h want %h", y_o, exp_y); end
      n_vec++;
      if (ctrl_o !== ctrl_t'(8'h5A)) begin n_err++; $display("FAIL desc_ctrl: got %h want 5a", ctrl_o); end
      tick();
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL desc_single: valid_o got %b want 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      vec_t exp_a;
      vec_t exp_d;
      exp_a   = v8(1, 2, 3, 4, 5, 6, 7, 8);
      exp_d   = v8(8, 7, 6, 5, 4, 3, 2, 1);
      valid_i = 1'b1;
      dir_i   = 1'b1;
      ctrl_i  = ctrl_t'(8'h11);
      x_i     = v8(1, 3, 5, 7, 2, 4, 6, 8);
      tick();
      dir_i   = 1'b0;
      ctrl_i  = ctrl_t'(8'h22);
      x_i     = v8(7, 5, 3, 1, 8, 6, 4, 2);
      tick();
      idle_inputs();
      tick();
      n_vec++;
      if (valid_o !== 1'b1 || y_o !== exp_a) begin
         n_err++; $display("FAIL b2b_asc: got v=%b %h want v=1 %h", valid_o, y_o, exp_a);
      end
      n_vec++;
      if (ctrl_o !== ctrl_t'(8'h11)) begin n_err++; $display("FAIL b2b_asc_ctrl: got %h want 11", ctrl_o); end
      tick();
      n_vec++;
      if (valid_o !== 1'b1 || y_o !== exp_d) begin
         n_err++; $display("FAIL b2b_desc: got v=%b %h want v=1 %h", valid_o, y_o, exp_d);
      end
      n_vec++;
      if (ctrl_o !== ctrl_t'(8'h22)) begin n_err++; $display("FAIL b2b_desc_ctrl: got %h want 22", ctrl_o); end
      tick();
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_tail: valid_o got %b want 0", valid_o); end
   endtask

   task automatic test_duplicates();
      vec_t exp_y;
      exp_y   = v8(5, 5, 5, 3, 2, 1, 0, 0);
      valid_i = 1'b1;
      dir_i   = 1'b0;
      ctrl_i  = ctrl_t'(8'h33);
      x_i     = v8(5, 5, 2, 0, 5, 3, 1, 0);
      tick();
      idle_inputs();
      tick();
      tick();
      n_vec++;
      if (valid_o !== 1'b1 || y_o !== exp_y) begin
         n_err++; $display("FAIL dup_y: got v=%b %h want v=1 %h", valid_o, y_o, exp_y);
      end
`ifdef TOPK_BE_IDX_EN
      begin
         tvec_t exp_t;
         exp_t[0] = 8'd0; exp_t[1] = 8'd1; exp_t[2] = 8'd4; exp_t[3] = 8'd5;
         exp_t[4] = 8'd2; exp_t[5] = 8'd6; exp_t[6] = 8'd3; exp_t[7] = 8'd7;
         n_vec++;
         if (y_idx_o !== exp_t) begin n_err++; $display("FAIL dup_tags: got %h want %h", y_idx_o, exp_t); end
      end
`endif
      tick();
   endtask

   task automatic test_backpressure();
      vec_t  in_v  [6];
      vec_t  exp_v [6];
      vec_t  held_y;
      ctrl_t held_c;
      logic  held;
      int    sent;
      int    rcvd;
      vec_t  raw;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) raw[i] = W'(i * 37 + k * 53);
         in_v[k]  = half_sorted(raw, k[0]);
         exp_v[k] = sort_range(raw, 0, N - 1, k[0]);
      end
      sent = 0;
      rcvd = 0;
      held = 1'b0;
      for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
         ready_i = !(cyc >= 4 && cyc <= 6);
         if (sent < 6) begin
            valid_i = 1'b1;
            x_i     = in_v[sent];
            dir_i   = sent[0];
            ctrl_i  = ctrl_t'(8'h80 + sent);
         end else begin
            idle_inputs();
         end
         #1;
         n_vec++;
         if (ready_o !== !(valid_o && !ready_i)) begin
            n_err++; $display("FAIL bp_ready cyc%0d: got %b valid_o=%b ready_i=%b", cyc, ready_o, valid_o, ready_i);
         end
         if (held) begin
            n_vec++;
            if (valid_o !== 1'b1 || y_o !== held_y || ctrl_o !== held_c) begin
               n_err++; $display("FAIL bp_hold cyc%0d: got v=%b %h %h want v=1 %h %h", cyc, valid_o, y_o, ctrl_o, held_y, held_c);
            end
         end
         held   = valid_o && !ready_i;
         held_y = y_o;
         held_c = ctrl_o;
         if (valid_o && ready_i) begin
            n_vec++;
            if (y_o !== exp_v[rcvd] || ctrl_o !== ctrl_t'(8'h80 + rcvd)) begin
               n_err++; $display("FAIL bp_out%0d: got %h ctrl %h want %h ctrl %h", rcvd, y_o, ctrl_o, exp_v[rcvd], 8'h80 + rcvd);
            end
            rcvd++;
         end
         if (valid_i && ready_o) sent++;
         @(posedge clk);
         #1;
      end
      idle_inputs();
      ready_i = 1'b1;
      n_vec++;
      if (rcvd != 6) begin n_err++; $display("FAIL bp_count: got %0d vectors want 6", rcvd); end
      tick();
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_extra: valid_o got %b want 0", valid_o); end
   endtask

   task automatic test_reset_midstream();
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         valid_i = 1'b1;
         dir_i   = 1'b1;
         ctrl_i  = ctrl_t'(8'hC0 + k);
         x_i     = v8(1 + k, 3, 5, 7, 2, 4, 6, 8);
         tick();
      end
      idle_inputs();
      n_vec++;
      if (valid_o !== 1'b1) begin n_err++; $display("FAIL rst_pre: valid_o got %b want 1", valid_o); end
      ready_i = 1'b0;
      #2;
      rstn_i = 1'b0;
      #1;
      n_vec++;
      if (valid_o !== 1'b0 || y_o !== '0 || ctrl_o !== '0) begin
         n_err++; $display("FAIL rst_async: got v=%b y=%h c=%h want all 0", valid_o, y_o, ctrl_o);
      end
      n_vec++;
      if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready_o); end
      tick();
      rstn_i  = 1'b1;
      ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_vec++;
         if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_stale c%0d: valid_o got %b want 0", c, valid_o); end
      end
   endtask

   task automatic test_random_stream();
      localparam int NV = 40;
      vec_t in_v  [NV];
      vec_t exp_v [NV];
      vec_t raw;
      int   k;
      for (int j = 0; j < NV; j++) begin
         for (int i = 0; i < N; i++) raw[i] = W'($urandom_range(0, 255));
         in_v[j]  = half_sorted(raw, j[0]);
         exp_v[j] = sort_range(raw, 0, N - 1, j[0]);
      end
      ready_i = 1'b1;
      for (int cyc = 0; cyc < NV + S + 1; cyc++) begin
         if (cyc < NV) begin
            valid_i = 1'b1;
            x_i     = in_v[cyc];
            dir_i   = cyc[0];
            ctrl_i  = ctrl_t'(cyc);
         end else begin
            idle_inputs();
         end
         k = cyc - S;
         n_vec++;
         if (k >= 0 && k < NV) begin
            if (valid_o !== 1'b1 || y_o !== exp_v[k] || ctrl_o !== ctrl_t'(k)) begin
               n_err++; $display("FAIL rnd_out%0d: got v=%b %h c=%h want v=1 %h c=%h", k, valid_o, y_o, ctrl_o, exp_v[k], k[7:0]);
            end
`ifdef TOPK_BE_IDX_EN
            for (int i = 0; i < N; i++) begin
               n_vec++;
               if (in_v[k][y_idx_o[i][2:0]] !== y_o[i] || y_idx_o[i][IW-1:3] !== '0) begin
                  n_err++; $display("FAIL rnd_tag%0d[%0d]: tag %0d value %h", k, i, y_idx_o[i], y_o[i]);
               end
            end
`endif
         end else if (valid_o !== 1'b0) begin
            n_err++; $display("FAIL rnd_latency cyc%0d: valid_o got %b want 0", cyc, valid_o);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_desc();
      test_back_to_back();
      test_duplicates();
      test_backpressure();
      test_reset_midstream();
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bitonic_merge_be_n.md
# bitonic_merge_be_n

Parametrised, pipelined bitonic merge backend for the top-k datapath. It accepts one N-element vector per cycle, given as two halves each already sorted in the requested direction, and emits the fully merged vector log2(N) cycles later. Runtime sort direction and valid/ready backpressure are supported. It sits after the per-half sorters in topk and replaces the fixed 8-input backend for any power-of-two width.

## Interface
- DATAWIDTH, 8, bits per element
- DATALENGTH, 8, elements per vector N; power of two, at least 4
- IDXWIDTH, 8, index tag width; used only with TOPK_BE_IDX_EN
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- valid_i  in  1  input vector valid
- ready_o  out  1  backend can accept this cycle
- dir_i  in  1  direction: 0 = descending (largest at index 0), 1 = ascending
- ctrl_i  in  ctrl_t  sideband, travels with the vector
- x_i  in  [DATAWIDTH-1:0] x DATALENGTH  input elements
- x_idx_i  in  [IDXWIDTH-1:0] x DATALENGTH  element index tags (macro only)
- valid_o  out  1  output vector valid
- ready_i  in  1  downstream accepts
- ctrl_o  out  ctrl_t  sideband of the output vector
- y_o  out  [DATAWIDTH-1:0] x DATALENGTH  merged elements
- y_idx_o  out  [IDXWIDTH-1:0] x DATALENGTH  tags following their elements (macro only)

## Operation
- S = log2(N) register stages. Each stage holds data, dir, ctrl, and a valid bit.
- Stage 1 (flip): compare-exchange pairs (i, N-1-i) for i < N/2.
- Stage s = 2..S: distance d = N/2^s. Within each block of 2d, compare-exchange pairs (i, i+d).
- Compare-exchange, descending: the larger element goes to the lower index. Ascending: the smaller element goes to the lower index.
- Swap only on strict inequality. Equal elements keep their positions, so tags are deterministic.
- Unsigned comparison.
- dir is sampled with the vector and applied at every stage from that stage's copy. Mixed directions in flight are legal.
- Input contract: x_i[0..N/2-1] and x_i[N/2..N-1] are each sorted in direction dir_i.
  - If the contract is violated, the output is deterministic but unspecified as a sorted order.

## Timing
- Global enable: en = ready_i | ~valid_o.
- ready_o = en. This is combinational from ready_i and valid_o.
- Transfer in when valid_i & ready_o. Transfer out when valid_o & ready_i.
- When en = 1, all stages advance. Stage-1 valid loads valid_i. Bubbles are not collapsed.
- When en = 0, every stage register holds, including the valid bits.
- Latency: S cycles from input transfer to valid_o, when there are no stalls. Throughput: one vector per cycle.
- Reset (asynchronous, any time): all stage valids = 0, y_o = 0, y_idx_o = 0, ctrl_o = '0, stored dir = 0. In-flight vectors are discarded.
- ready_o = 1 as soon as reset is asserted.
- y_o and ctrl_o are stable while valid_o = 1 and ready_i = 0.

## Configuration
- TOPK_BE_IDX_EN defined: x_idx_i and y_idx_o ports exist. Tags are registered alongside data and swapped with their element at every compare-exchange.
- TOPK_BE_IDX_EN undefined: the tag ports and registers are absent. Data, ctrl, and timing behaviour are identical.

## Structure
- topk_pkg: ctrl_t (existing), new enum sort_dir_e {SORT_DESC = 1'b0, SORT_ASC = 1'b1}, and function clog2-based stage count helper.
- Sub-module bitonic_cas_en: one registered compare-exchange with enable, direction input, async active-low reset, optional tag pair under the same macro.
- The top module generates the S stage columns of N/2 instances. It also holds the per-stage valid/dir/ctrl pipeline.

## Test plan
- N=8, dir=0, ready_i=1, x={7,5,3,1,8,6,4,2} -> after 3 cycles y_o={8,7,6,5,4,3,2,1}, valid_o high for exactly one cycle.
- N=8, dir=1, x={1,3,5,7,2,4,6,8}, then the dir=0 vector above on the next cycle -> consecutive outputs {1..8} ascending, then {8..1}; ctrl_o matches each input's ctrl_i.
- Duplicates with tags (macro on), dir=0, x={5,5,2,0,5,3,1,0}, idx=0..7 -> y_o={5,5,5,3,2,1,0,0}; equal values are not reordered among the swap decisions, and tag order is checked against the golden model.
- Backpressure: stream 6 vectors with ready_i low on cycles 4–6 -> no vector lost or duplicated, outputs held stable while stalled, ready_o low exactly while valid_o & ~ready_i.
- Reset mid-stream: assert rstn_i with 3 vectors in flight -> valid_o=0 and y_o=0 immediately, no stale vector appears after release.
- N=16 and N=4 builds: random half-sorted vectors, 1000 each direction -> match the sorted reference model, latency 4 and 2 respectively.
